univ_shift_reg: RTL
===================

# univ_shift_reg

Parametrised universal shift register: successor to the fixed 4-bit serial-in/serial-out register. Adds configurable width, bidirectional shift, rotate, parallel load, synchronous clear and clock-enable, plus a frame counter that flags every WIDTH consecutive shifts so the block can serve as a serializer/deserializer front end.

## Interface
- WIDTH, 8, register width in bits; legal range WIDTH >= 2
- CW, $clog2(WIDTH), frame counter width; derived, not overridden
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  clock enable; 0 holds all state
- mode  in  3  operation select; encoding under Operation
- si_l  in  1  serial input for shift-left; enters bit 0
- si_r  in  1  serial input for shift-right; enters bit WIDTH-1
- pin  in  WIDTH  parallel load data
- pout  out  WIDTH  register contents q
- so_l  out  1  q[WIDTH-1], left serial output
- so_r  out  1  q[0], right serial output
- cnt  out  CW  shifts completed in the current frame, 0..WIDTH-1
- frame_done  out  1  one-cycle pulse marking completion of a WIDTH-shift frame

## Operation
- Mode encoding, applied when en=1:
  - 000 hold: q, cnt unchanged
  - 001 shift left: q <= {q[WIDTH-2:0], si_l}
  - 010 shift right: q <= {si_r, q[WIDTH-1:1]}
  - 011 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}
  - 100 rotate right: q <= {q[0], q[WIDTH-1:1]}
  - 101 parallel load: q <= pin; cnt <= 0
  - 110 clear: q <= 0; cnt <= 0
  - 111 reserved: behaves exactly as hold
- Shift ops are modes 001–100. Each shift op increments cnt. When cnt = WIDTH-1 and a shift op executes, cnt wraps to 0 and frame_done is asserted for the following cycle.
- frame_done is registered. It is 1 only in the cycle after the wrapping edge and 0 otherwise, including during hold, load, clear, en=0 and reset.
- en=0: q and cnt held; frame_done cleared to 0 on that edge.
- pin, si_l and si_r are ignored in modes that do not use them.
- so_l, so_r and pout are direct views of q. They add no extra register stage.

## Timing
- Reset: on a rising edge with rst=1, q=0, cnt=0 and frame_done=0. So pout=0, so_l=0, so_r=0. rst has priority over en and mode.
- Reset mid-frame discards the partial count. The next frame needs a full WIDTH shifts.
- Operation latency: 1 cycle. The effect of mode is visible on pout the cycle after the edge.
- SISO latency, shift left: a bit sampled on si_l appears on so_l after exactly WIDTH enabled shift edges. Shift right with si_r to so_r behaves the same.
- frame_done aligns with the SISO latency. For a bit entered at cnt=0, frame_done is high in the same cycle that bit first shows on the far serial output.
- Mixing shift directions within a frame is legal. Every shift op counts regardless of direction.
- Load or clear on the same edge that would have wrapped: load/clear wins, cnt=0, no frame_done.
- en is sampled every edge. There is no handshake beyond en; the upstream stage must hold inputs stable around the edge.

## Test plan
- Reset: load pin=0xA5, then rst=1 for 1 cycle with mode=001 -> pout=0x00, cnt=0, frame_done=0. Asserting rst with en=0 gives the same result.
- Shift left: load 0xA5, then 3× mode 001 with si_l=1 -> pout 0x4B, 0x97, 0x2F; so_l 0, 1, 0; cnt 1, 2, 3.
- Rotate: load 0x81, 1× mode 100 -> 0xC0. Reload 0x81, then 8× mode 100 -> 0x81, with frame_done high only in the cycle after the 8th edge and cnt=0.
- SISO latency: after clear, si_l=1 for one shift, then si_l=0 for 7 shifts -> so_l first =1 after the 8th edge, coincident with frame_done=1. so_l is 0 before that.
- Enable/interrupt: 3 shifts (cnt=3), then en=0 for 4 cycles -> q and cnt frozen, frame_done=0. Resume with 5 shifts -> frame_done pulse. Separately, 3 shifts then load 0xFF -> cnt=0, pout=0xFF.
- Clear/reserved: pout=0x3C, mode 111 for 2 cycles -> pout=0x3C, cnt unchanged. Then mode 110 -> pout=0x00, cnt=0.

Source files
------------

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with rotate, load, clear and WIDTH-shift frame counter
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             si_l,
  input  logic             si_r,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] pout,
  output logic             so_l,
  output logic             so_r,
  output logic [CW-1:0]    cnt,
  output logic             frame_done
);

  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             frame_done_q, frame_done_d;
  logic             is_shift;

  always_comb begin
    q_d          = q_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    is_shift     = 1'b0;
    if (en) begin
      case (mode)
        MODE_SHL: begin
          q_d      = {q_q[WIDTH-2:0], si_l};
          is_shift = 1'b1;
        end
        MODE_SHR: begin
          q_d      = {si_r, q_q[WIDTH-1:1]};
          is_shift = 1'b1;
        end
        MODE_ROL: begin
          q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          is_shift = 1'b1;
        end
        MODE_ROR: begin
          q_d      = {q_q[0], q_q[WIDTH-1:1]};
          is_shift = 1'b1;
        end
        MODE_LOAD: begin
          q_d   = pin;
          cnt_d = '0;
        end
        MODE_CLR: begin
          q_d   = '0;
          cnt_d = '0;
        end
        default: ;
      endcase
      // Any shift direction counts toward the frame; the wrap raises frame_done for one cycle.
      if (is_shift) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q          <= '0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      q_q          <= q_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pout       = q_q;
  assign so_l       = q_q[WIDTH-1];
  assign so_r       = q_q[0];
  assign cnt        = cnt_q;
  assign frame_done = frame_done_q;

endmodule
